// File: rtl/ring_osc_pkg.sv
// ring_osc_pkg: shared types and helpers for the ring oscillator trim calibrator.
//   state_t   - calibration FSM state encoding
//   code_w    - width of a trim code covering 0..2*stages
//   therm_map - thermometer trim vector for a code (bit i set when i < k)
package ring_osc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_ADJUST,
        ST_LOCKED,
        ST_ERROR
    } state_t;

    localparam int TRIM_MAX = 64;

    function automatic int code_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    // Primary bits sit below secondary bits, so a plain thermometer of k
    // fills every primary stage before touching any secondary one.
    function automatic logic [TRIM_MAX-1:0] therm_map(input int k);
        logic [TRIM_MAX-1:0] r;
        for (int i = 0; i < TRIM_MAX; i++) r[i] = (i < k);
        return r;
    endfunction

endpackage

// File: rtl/ring_osc_trim_map.sv
// ring_osc_trim_map: combinational trim code to thermometer trim mapping.
//   code_i - trim code; values above 2*STAGES clamp to 2*STAGES
//   trim_o - 2*STAGES thermometer trim (primary bits [STAGES-1:0] first)
module ring_osc_trim_map
    import ring_osc_pkg::*;
#(
    parameter int STAGES = 13,
    parameter int CODE_W = code_w(STAGES)
) (
    input  logic [CODE_W-1:0]   code_i,
    output logic [2*STAGES-1:0] trim_o
);

    localparam int TW = 2 * STAGES;
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(TW);

    logic [CODE_W-1:0] k;

    always_comb begin
        k      = (code_i > CODE_MAX) ? CODE_MAX : code_i;
        trim_o = TW'(therm_map(int'(k)));
    end

endmodule

// File: rtl/ring_osc_trim_cal.sv
// ring_osc_trim_cal: closed-loop trim calibrator for a tunable ring oscillator.
//   clk, resetb        - system clock, asynchronous active-low reset
//   enable             - 1 runs the oscillator; 0 holds it in reset and aborts
//   start              - single-cycle calibration request
//   manual/manual_code - bypass calibration, code follows clamped manual_code
//   target/tolerance   - desired ticks per window and allowed deviation
//   osc_tick           - synchronised oscillator tick pulse
//   osc_reset, trim    - oscillator controls (trim lags code by one cycle)
//   code, count        - current trim code, last completed window count
//   busy/locked/error  - calibration status
module ring_osc_trim_cal
    import ring_osc_pkg::*;
#(
    parameter int STAGES    = 13,
    parameter int CNT_W     = 16,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 16,
    parameter int MAX_ITER  = 64,
    parameter int INIT_CODE = 13,
    parameter int TRACK     = 0,
    parameter int CODE_W    = code_w(STAGES)
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                enable,
    input  logic                start,
    input  logic                manual,
    input  logic [CODE_W-1:0]   manual_code,
    input  logic [CNT_W-1:0]    target,
    input  logic [CNT_W-1:0]    tolerance,
    input  logic                osc_tick,
    output logic                osc_reset,
    output logic [2*STAGES-1:0] trim,
    output logic [CODE_W-1:0]   code,
    output logic [CNT_W-1:0]    count,
    output logic                busy,
    output logic                locked,
    output logic                error
);

    localparam int TW     = 2 * STAGES;
    localparam int TMR_W  = $clog2((WINDOW > SETTLE ? WINDOW : SETTLE) + 1);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(TW);
    localparam logic [TW-1:0]     TRIM_INIT = TW'(therm_map(INIT_CODE));

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d, man_code;
    logic [TW-1:0]       trim_q, trim_d;
    logic [CNT_W-1:0]    count_q, count_d, acc_q, acc_d, acc_inc;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                busy_q, busy_d, locked_q, locked_d, error_q, error_d;
    logic                trk_q, trk_d, osc_reset_q;
    logic [CNT_W:0]      hi, lo;
    logic                fast, slow, iter_out;

    ring_osc_trim_map #(.STAGES(STAGES), .CODE_W(CODE_W)) u_map (
        .code_i (code_q),
        .trim_o (trim_d)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        count_d  = count_q;
        acc_d    = acc_q;
        tmr_d    = tmr_q;
        iter_d   = iter_q;
        busy_d   = busy_q;
        locked_d = locked_q;
        error_d  = error_q;
        trk_d    = trk_q;
        man_code = (manual_code > CODE_MAX) ? CODE_MAX : manual_code;
        acc_inc  = (&acc_q) ? acc_q : acc_q + CNT_W'(osc_tick);
        // One extra bit keeps target+tolerance and count+tolerance from wrapping.
        hi       = {1'b0, target} + {1'b0, tolerance};
        lo       = {1'b0, count_q} + {1'b0, tolerance};
        fast     = {1'b0, count_q} > hi;
        slow     = lo < {1'b0, target};
        // The step limit only bounds an initial calibration, never tracking.
        iter_out = !trk_q && (iter_q == ITER_W'(MAX_ITER));
        case (state_q)
            ST_IDLE, ST_LOCKED, ST_ERROR: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    tmr_d    = '0;
                    iter_d   = '0;
                    busy_d   = 1'b1;
                    locked_d = 1'b0;
                    error_d  = 1'b0;
                    trk_d    = 1'b0;
                end else if (state_q == ST_LOCKED && trk_q) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end
            end
            ST_SETTLE: begin
                acc_d   = '0;
                tmr_d   = (tmr_q == TMR_W'(SETTLE - 1)) ? '0 : tmr_q + 1'b1;
                state_d = (tmr_q == TMR_W'(SETTLE - 1)) ? ST_MEASURE : ST_SETTLE;
            end
            ST_MEASURE: begin
                acc_d = acc_inc;
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    count_d = acc_inc;
                    state_d = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                if (!fast && !slow) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                    busy_d   = 1'b0;
                    trk_d    = (TRACK != 0);
                end else if ((fast && code_q == CODE_MAX) || (slow && code_q == '0) || iter_out) begin
                    state_d  = ST_ERROR;
                    error_d  = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = 1'b0;
                end else begin
                    code_d   = fast ? code_q + 1'b1 : code_q - 1'b1;
                    iter_d   = iter_q + 1'b1;
                    tmr_d    = '0;
                    locked_d = 1'b0;
                    state_d  = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (manual) code_d = man_code;
        // Disable or manual override abort everything; the code is kept.
        if (!enable || manual) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            locked_d = 1'b0;
            trk_d    = 1'b0;
            error_d  = enable ? error_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            code_q      <= CODE_W'(INIT_CODE);
            trim_q      <= TRIM_INIT;
            count_q     <= '0;
            acc_q       <= '0;
            tmr_q       <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            trk_q       <= 1'b0;
            osc_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            trim_q      <= trim_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            tmr_q       <= tmr_d;
            iter_q      <= iter_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            trk_q       <= trk_d;
            osc_reset_q <= !enable;
        end
    end

    assign osc_reset = osc_reset_q;
    assign trim      = trim_q;
    assign code      = code_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign error     = error_q;

endmodule
